// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU's byte-wide memory port.
package cpu_mem_pkg;

  // Byte beats per 32-bit word transfer.
  localparam int BEATS     = 4;
  // Default size of the byte-array memory behind the port.
  localparam int MEM_BYTES = 256;

  // Port sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    LAST = 2'd2,
    ACK  = 2'd3
  } state_e;

  // Requester identity. The encoding is visible in last_grant.
  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_rr_arbiter2.sv
// Two-input round-robin grant for the memory port. On a tie the requester
// that did not win the previous grant wins. last_grant moves only when a
// grant is actually taken.
module mem_rr_arbiter2
  import cpu_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   fetch_req_i,
  input  logic   data_req_i,
  input  logic   grant_en_i,
  output logic   grant_valid_o,
  output owner_e grant_owner_o
);

  owner_e last_grant_q, last_grant_d;

  // Pick the winner and work out the next last_grant.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    grant_valid_o = fetch_req_i | data_req_i;
    grant_owner_o = FETCH;
    last_grant_d  = last_grant_q;

    if (fetch_req_i && data_req_i) begin
      grant_owner_o = (last_grant_q == DATA) ? FETCH : DATA;
    end else if (data_req_i) begin
      grant_owner_o = DATA;
    end

    if (grant_en_i && grant_valid_o) begin
      last_grant_d = grant_owner_o;
    end
  end

  // Hold the previous winner. After reset DATA counts as the last winner,
  // so fetch takes the first tie.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the values from before the edge, whatever the block order.
    if (rst) begin
      last_grant_q <= DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the byte-wide memory port between instruction fetch and load/store.
// A granted word request becomes four byte beats. Read bytes are assembled
// little-endian, and the request completes with a registered one-cycle ack.
module imem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction fetch requester
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic              o_if_ack,
  output logic [31:0]       o_if_rdata,
  // Load/store requester
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [31:0]       i_d_addr,
  input  logic [31:0]       i_d_wdata,
  input  logic [3:0]        i_d_be,
  output logic              o_d_ack,
  output logic [31:0]       o_d_rdata,
  // Byte memory port
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_busy
);

  localparam int WIDX_W = ADDR_W - 2;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  owner_e            owner_q, owner_d;
  logic [WIDX_W-1:0] widx_q, widx_d;     // word index; byte lane comes from beat
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [23:0]       asm_q, asm_d;       // bytes 0..2 of the word being read
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;

  logic              grant_valid;
  owner_e            grant_owner;

  // The byte offset and any bits above the array size are deliberately
  // dropped. Every access is word-aligned and wraps modulo the array size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr, i_d_addr};

  mem_rr_arbiter2 u_arb (
    .clk           (clk),
    .rst           (rst),
    .fetch_req_i   (i_if_req),
    .data_req_i    (i_d_req),
    .grant_en_i    (state_q == IDLE),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  // Sequencer next state: grant, beat counting, byte assembly, ack.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    owner_d    = owner_q;
    widx_d     = widx_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    asm_d      = asm_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          beat_d  = 2'd0;
          state_d = XFER;
          if (grant_owner == DATA) begin
            widx_d  = i_d_addr[ADDR_W-1:2];
            we_d    = i_d_we;
            wdata_d = i_d_wdata;
            be_d    = i_d_be;
          end else begin
            widx_d  = i_if_addr[ADDR_W-1:2];
            we_d    = 1'b0;
            wdata_d = '0;
            be_d    = '0;
          end
        end
      end

      XFER: begin
        // The memory read is registered, so this cycle carries the byte
        // addressed by the previous beat.
        if (!we_q) begin
          unique case (beat_q)
            2'd1:    asm_d[7:0]   = i_mem_rdata;
            2'd2:    asm_d[15:8]  = i_mem_rdata;
            2'd3:    asm_d[23:16] = i_mem_rdata;
            default: ;
          endcase
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'(BEATS - 1)) begin
          state_d = LAST;
        end
      end

      LAST: begin
        // Byte 3 arrives now. Publish the whole word to its owner only, so
        // the other requester's rdata stays stable.
        if (!we_q) begin
          if (owner_q == FETCH) begin
            if_rdata_d = {i_mem_rdata, asm_q};
          end else begin
            d_rdata_d  = {i_mem_rdata, asm_q};
          end
        end
        if (owner_q == FETCH) begin
          if_ack_d = 1'b1;
        end else begin
          d_ack_d  = 1'b1;
        end
        state_d = ACK;
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and output registers. A reset abandons any transfer in flight
  // without acking it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      owner_q    <= FETCH;
      widx_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      owner_q    <= owner_d;
      widx_q     <= widx_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
    end
  end

  // Assembly buffer for bytes 0..2.
  always_ff @(posedge clk) begin
    // NOTE: this buffer has no reset on purpose. Every read overwrites all
    // three bytes before LAST consumes them, so a stale value never escapes.
    asm_q <= asm_d;
  end

  // Drive the memory port only while beats are being issued.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state_q == XFER) begin
      o_mem_en   = 1'b1;
      o_mem_we   = we_q & be_q[beat_q];
      o_mem_addr = {widx_q, beat_q};
      unique case (beat_q)
        2'd0:    o_mem_wdata = wdata_q[7:0];
        2'd1:    o_mem_wdata = wdata_q[15:8];
        2'd2:    o_mem_wdata = wdata_q[23:16];
        default: o_mem_wdata = wdata_q[31:24];
      endcase
    end
  end

  assign o_if_ack   = if_ack_q;
  assign o_d_ack    = d_ack_q;
  assign o_if_rdata = if_rdata_q;
  assign o_d_rdata  = d_rdata_q;
  assign o_busy     = (state_q != IDLE);

endmodule
